// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg - parametrised UART transmitter with an internal bit-period counter.
//
// Frame: start(0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Each bit lasts BPS = CLK_FREQ/BAUD_RATE cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   din        in   word to send (DATA_BITS wide)
//   din_valid  in   din is valid
//   din_ready  out  word accepted on this edge when din_valid is also high
//   txd        out  serial line, idle high (registered)
//   busy       out  frame in progress
//   done       out  one-cycle pulse in the first idle cycle after a frame (registered)
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 65_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int BPS = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(BPS - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    if (BPS < 2) begin : g_chk_bps
        $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   txd_d, done_d;
    logic                   tick;

    assign din_ready = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            txd     <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            txd     <= txd_d;
            done    <= done_d;
        end
    end

    // Next-state logic. idx counts data bits in DATA and stop bits in STOP,
    // so two stop bits are one STOP state lasting 2*BPS cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tick    = (cnt_q == CNT_LAST);

        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (din_valid && din_ready) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shreg_d = din;
                    par_d   = (PARITY == 1) ? ~^din : ^din;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == DATA_LAST) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: txd/done are computed from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        txd_d  = 1'b1;
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        unique case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
            ST_PARITY: txd_d = par_q;
            default:   txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: three instances (8N1, 7E2, 8O1) at BPS = 10,
// checked every cycle against a queue-based line model, plus literal
// expectations on decoded frames and timing.
module tb_uart_tx_cfg;

    localparam int BPS = 10;
    localparam int NI  = 3;
    localparam int DBA [NI] = '{8, 7, 8};
    localparam int PMA [NI] = '{0, 2, 1};
    localparam int SBA [NI] = '{1, 2, 1};

    logic            clk;
    logic            rst;
    logic [8:0]      din_a [NI];
    logic [NI-1:0]   dv_v;
    logic [NI-1:0]   rdy_v;
    logic [NI-1:0]   txd_v;
    logic [NI-1:0]   busy_v;
    logic [NI-1:0]   done_v;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = DBA[g];
        uart_tx_cfg #(
            .CLK_FREQ  (1_000_000),
            .BAUD_RATE (100_000),
            .DATA_BITS (W),
            .PARITY    (PMA[g]),
            .STOP_BITS (SBA[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din       (din_a[g][W-1:0]),
            .din_valid (dv_v[g]),
            .din_ready (rdy_v[g]),
            .txd       (txd_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural line model ----------------
    // Each accepted word becomes a queue of per-cycle line levels; the frame
    // ends when the queue runs dry, which is the done cycle.
    bit q [NI][$];
    bit in_fr [NI];
    bit e_txd [NI];
    bit e_done [NI];

    initial begin
        for (int g = 0; g < NI; g++) begin
            in_fr[g]  = 1'b0;
            e_txd[g]  = 1'b1;
            e_done[g] = 1'b0;
        end
    end

    always @(posedge clk) begin
        int ones;
        bit pb;
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                q[g].delete();
                in_fr[g]  = 1'b0;
                e_txd[g]  = 1'b1;
                e_done[g] = 1'b0;
            end else if (in_fr[g]) begin
                if (q[g].size() > 0) begin
                    e_txd[g]  = q[g].pop_front();
                    e_done[g] = 1'b0;
                end else begin
                    in_fr[g]  = 1'b0;
                    e_txd[g]  = 1'b1;
                    e_done[g] = 1'b1;
                end
            end else begin
                e_done[g] = 1'b0;
                e_txd[g]  = 1'b1;
                if (dv_v[g]) begin
                    ones = 0;
                    for (int b = 0; b < BPS; b++) q[g].push_back(1'b0);
                    for (int i = 0; i < DBA[g]; i++) begin
                        pb = din_a[g][i];
                        ones += int'(pb);
                        for (int b = 0; b < BPS; b++) q[g].push_back(pb);
                    end
                    if (PMA[g] != 0) begin
                        pb = (ones % 2 == 1);          // even parity bit
                        if (PMA[g] == 1) pb = !pb;     // odd parity bit
                        for (int b = 0; b < BPS; b++) q[g].push_back(pb);
                    end
                    for (int b = 0; b < SBA[g] * BPS; b++) q[g].push_back(1'b1);
                    in_fr[g] = 1'b1;
                    e_txd[g] = q[g].pop_front();
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int cycle  = 0;
    int rec_g  = 0;
    bit rec [$];

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    endtask

    // Advance one cycle, then compare all instances with the model.
    task automatic cyc();
        @(negedge clk);
        cycle++;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("txd[%0d]@%0d", g, cycle),   int'(txd_v[g]),  int'(e_txd[g]));
            check($sformatf("done[%0d]@%0d", g, cycle),  int'(done_v[g]), int'(e_done[g]));
            check($sformatf("busy[%0d]@%0d", g, cycle),  int'(busy_v[g]), int'(in_fr[g]));
            check($sformatf("ready[%0d]@%0d", g, cycle), int'(rdy_v[g]),  int'(!in_fr[g] && !rst));
        end
        rec.push_back(txd_v[rec_g]);
    endtask

    // Sample n bit periods starting at period 'per' of a frame whose start
    // bit begins at rec index s; LSB first.
    function automatic int dec(input int s, input int per, input int n);
        int v = 0;
        int ix;
        for (int k = 0; k < n; k++) begin
            ix = s + (per + k) * BPS + BPS / 2;
            if (ix >= rec.size()) return -1;
            v |= int'(rec[ix]) << k;
        end
        return v;
    endfunction

    function automatic int ones_in(input int s, input int per, input int n);
        int c = 0;
        for (int ix = s + per * BPS; ix < s + (per + n) * BPS; ix++) begin
            if (ix >= rec.size()) return -1;
            c += int'(rec[ix]);
        end
        return c;
    endfunction

    // Send one word on instance g; lat = cycles from first start-bit cycle
    // to the done cycle (-1 on timeout), rlow = ready-low cycles before done.
    task automatic send_frame(input int g, input int data, output int lat, output int rlow);
        din_a[g] = 9'(data);
        dv_v[g]  = 1'b1;
        rec.delete();
        rec_g    = g;
        cyc();
        dv_v[g]  = 1'b0;
        lat      = -1;
        rlow     = 0;
        for (int i = 1; i <= 300; i++) begin
            if (!rdy_v[g]) rlow++;
            cyc();
            if (done_v[g]) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, rlow, nd, d1, d2, bc;
        rst  = 1'b1;
        dv_v = '0;
        for (int g = 0; g < NI; g++) din_a[g] = '0;

        // reset state
        cyc();
        cyc();
        check("rst_txd",   int'(txd_v),  7);
        check("rst_done",  int'(done_v), 0);
        check("rst_busy",  int'(busy_v), 0);
        check("rst_ready", int'(rdy_v),  0);
        rst = 1'b0;
        cyc();
        check("idle_ready", int'(rdy_v), 7);

        // 1: 8N1, 0x55
        send_frame(0, 'h55, lat, rlow);
        check("t1_latency",  lat,  100);
        check("t1_rdy_low",  rlow, 100);
        check("t1_pattern",  dec(0, 0, 10), 'h2AA);
        repeat (3) cyc();

        // 2: 7E2, 0x41
        send_frame(1, 'h41, lat, rlow);
        check("t2_latency", lat, 110);
        check("t2_data",    dec(0, 1, 7), 'h41);
        check("t2_parity",  dec(0, 8, 1), 0);
        check("t2_stop",    ones_in(0, 9, 2), 20);
        repeat (3) cyc();

        // 3: 8O1, 0x00 then 0x01
        send_frame(2, 'h00, lat, rlow);
        check("t3a_latency", lat, 110);
        check("t3a_data",    dec(0, 1, 8), 'h00);
        check("t3a_parity",  dec(0, 9, 1), 1);
        send_frame(2, 'h01, lat, rlow);
        check("t3b_latency", lat, 110);
        check("t3b_data",    dec(0, 1, 8), 'h01);
        check("t3b_parity",  dec(0, 9, 1), 0);
        repeat (3) cyc();

        // 4: 8N1 back-to-back with din_valid held high
        din_a[0] = 9'h0A5;
        dv_v[0]  = 1'b1;
        rec.delete();
        rec_g    = 0;
        cyc();
        din_a[0] = 9'h03C;
        nd = 0; d1 = -1; d2 = -1;
        for (int i = 1; i <= 260; i++) begin
            cyc();
            if (done_v[0]) begin
                nd++;
                if (d1 < 0) d1 = i;
                else d2 = i;
            end
            if (d1 >= 0 && i == d1 + 1) dv_v[0] = 1'b0;
        end
        dv_v[0] = 1'b0;
        check("t4_done_count", nd, 2);
        check("t4_done1_at",   d1, 100);
        check("t4_done2_at",   d2, 201);
        check("t4_gap_high",   int'(rec[100]), 1);
        check("t4_start2",     int'(rec[101]), 0);
        check("t4_byte1",      dec(0, 1, 8),   'hA5);
        check("t4_byte2",      dec(101, 1, 8), 'h3C);

        // 5: reset 35 cycles into a 0x00 frame, then send 0xFF
        din_a[0] = 9'h000;
        dv_v[0]  = 1'b1;
        rec.delete();
        rec_g    = 0;
        cyc();
        dv_v[0]  = 1'b0;
        repeat (34) cyc();
        check("t5_txd_before", int'(txd_v[0]), 0);
        rst = 1'b1;
        cyc();
        check("t5_txd_after",  int'(txd_v[0]),  1);
        check("t5_busy_after", int'(busy_v[0]), 0);
        rst = 1'b0;
        nd = 0;
        repeat (120) begin
            cyc();
            if (done_v[0]) nd++;
        end
        check("t5_no_done", nd, 0);
        send_frame(0, 'hFF, lat, rlow);
        check("t5_latency", lat, 100);
        check("t5_data",    dec(0, 1, 8), 'hFF);
        repeat (3) cyc();

        // 6: 8O1, din changes every cycle and din_valid pulses while busy
        din_a[2] = 9'h05A;
        dv_v[2]  = 1'b1;
        rec.delete();
        rec_g    = 2;
        cyc();
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            din_a[2] = 9'($urandom);
            dv_v[2]  = 1'($urandom_range(0, 1));
            cyc();
            if (done_v[2]) begin
                dv_v[2] = 1'b0;
                lat = i;
                break;
            end
        end
        dv_v[2] = 1'b0;
        check("t6_latency", lat, 110);
        check("t6_data",    dec(0, 1, 8), 'h5A);
        check("t6_parity",  dec(0, 9, 1), 1);
        nd = 0; bc = 0;
        repeat (150) begin
            cyc();
            if (done_v[2]) nd++;
            if (busy_v[2]) bc++;
        end
        check("t6_no_extra_done", nd, 0);
        check("t6_no_extra_busy", bc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
